deser_register: RTL and testbench

Serial-to-parallel capture register that sits directly downstream of the 1-bit register stage. It consumes one bit per accepted cycle and assembles the bits into a WIDTH-bit word. It presents that word on a parallel output with a valid/ready handshake. It is the standard consumer for single-bit register chains feeding word-wide datapaths.

---
 rtl/deser_register.sv | 125 ++++++++++++
 tb/tb_deser_register.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/deser_register.sv
// deser_register: serial-to-parallel capture register.
// Bits accepted one per cycle are shifted into an internal register. The
// WIDTH-th bit completes the word, which is loaded straight into the
// output slot q together with that bit, and then offered downstream with
// a valid/ready handshake. Only the completing bit is ever held off by
// backpressure, so a completed word can never be lost.
module deser_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d,
    input  logic                     d_valid,
    output logic                     d_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(WIDTH)-1:0] fill
);

    localparam int                FILL_W = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] LAST   = FILL_W'(WIDTH - 1);

    // Shift one bit into the partial word. LSB-first shifts right so the
    // first bit ends up in bit 0; MSB-first shifts left so it ends up in
    // the top bit.
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] cur,
        input logic             b
    );
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[WIDTH-2:0], b};
        end else begin
            res = {b, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Partial-word shift register (not visible outside the block).
    logic [WIDTH-1:0]  sreg;

    // Next-state values.
    logic [WIDTH-1:0]  sreg_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              q_valid_nxt;

    // Handshake decode.
    logic              last_bit;
    logic              stall;
    logic              accept;
    logic              complete;
    logic              consume;
    logic [WIDTH-1:0]  shifted;

    // The next accepted bit completes the word.
    assign last_bit = (fill == LAST);

    // A completing bit must wait while the output slot is full and not
    // draining this cycle; earlier bits never wait.
    assign stall    = last_bit && q_valid && !q_ready;

    // d_ready is combinational on q_ready so the stall releases on the very
    // edge the downstream consumes the held word. Held low during reset.
    assign d_ready  = rst && !stall;

    // flush wins over a same-cycle input bit, which is simply dropped.
    assign accept   = d_valid && d_ready && !flush;
    assign complete = accept && last_bit;
    assign consume  = q_valid && q_ready;

    // Partial word with the incoming bit included; on completion this is
    // exactly the word that lands in q.
    assign shifted  = shift_in(sreg, d);

    // Next-state logic for the shift register, fill counter and output slot.
    always_comb begin
        sreg_nxt    = sreg;
        fill_nxt    = fill;
        q_nxt       = q;
        q_valid_nxt = q_valid;

        if (flush) begin
            // Discard the partial word only; the output slot is untouched.
            sreg_nxt = '0;
            fill_nxt = '0;
        end else if (accept) begin
            if (last_bit) begin
                sreg_nxt = '0;
                fill_nxt = '0;
            end else begin
                sreg_nxt = shifted;
                fill_nxt = fill + FILL_W'(1);
            end
        end

        // A load on the same edge as a consume keeps q_valid high, giving
        // back-to-back words without a bubble.
        if (complete) begin
            q_nxt       = shifted;
            q_valid_nxt = 1'b1;
        end else if (consume) begin
            q_valid_nxt = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg    <= '0;
            fill    <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            sreg    <= sreg_nxt;
            fill    <= fill_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
        end
    end

endmodule

// File: tb/tb_deser_register.sv
// Bench for deser_register: one LSB-first and one MSB-first instance share
// all inputs. Expected words are queued as each word is sent; a monitor
// pops and compares whenever a word is handed off (q_valid && q_ready).
module tb_deser_register;

    localparam int W  = 8;
    localparam int FW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          d;
    logic          d_valid;
    logic          flush;
    logic          q_ready;

    logic          dr_a, dr_b;
    logic [W-1:0]  q_a, q_b;
    logic          qv_a, qv_b;
    logic [FW-1:0] fill_a, fill_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    always #5 clk = ~clk;

    deser_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(dr_a),
        .flush(flush), .q(q_a), .q_valid(qv_a), .q_ready(q_ready), .fill(fill_a)
    );

    deser_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(dr_b),
        .flush(flush), .q(q_b), .q_valid(qv_b), .q_ready(q_ready), .fill(fill_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (qv_a && q_ready) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL word_a: unexpected word %0h", q_a);
            end else begin
                chk("word_a", 32'(q_a), 32'(exp_a.pop_front()));
            end
        end
        if (qv_b && q_ready) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL word_b: unexpected word %0h", q_b);
            end else begin
                chk("word_b", 32'(q_b), 32'(exp_b.pop_front()));
            end
        end
    end

    // One accepted bit: drive, let one edge pass, return just after it.
    task automatic send_bit(input logic b);
        d = b;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Send a word LSB of w first; ea/eb are the hand-computed results.
    task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] ea,
                             input logic [W-1:0] eb, input bit push);
        if (push) begin
            exp_a.push_back(ea);
            exp_b.push_back(eb);
        end
        for (int i = 0; i < W; i++) send_bit(w[i]);
        d_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; d = 1'b1; d_valid = 1'b1; flush = 1'b0; q_ready = 1'b0;

        // Reset with input active
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_q", 32'(q_a), 32'h0);
            chk("rst_qv", 32'(qv_a), 32'h0);
            chk("rst_fill", 32'(fill_a), 32'h0);
            chk("rst_dready", 32'(dr_a), 32'h0);
        end
        rst = 1'b1; d_valid = 1'b0;
        #1;
        chk("rel_dready", 32'(dr_a), 32'h1);

        // LSB-first word 1,0,1,0,0,1,0,1 -> A5 (bit-reverse is also A5)
        q_ready = 1'b1;
        send_word(8'hA5, 8'hA5, 8'hA5, 1'b1);
        chk("a5_qv", 32'(qv_a), 32'h1);
        chk("a5_q", 32'(q_a), 32'hA5);
        chk("a5_fill", 32'(fill_a), 32'h0);
        @(posedge clk); #1;
        chk("a5_qv_one_cycle", 32'(qv_a), 32'h0);

        // Backpressure: 0x3C held, then 0xFF stalls on its last bit
        q_ready = 1'b0;
        send_word(8'h3C, 8'h3C, 8'h3C, 1'b1);
        chk("bp_q3c", 32'(q_a), 32'h3C);
        exp_a.push_back(8'hFF);
        exp_b.push_back(8'hFF);
        for (int i = 0; i < W - 1; i++) send_bit(1'b1);
        d = 1'b1; d_valid = 1'b1;
        @(negedge clk);
        chk("bp_fill7", 32'(fill_a), 32'h7);
        chk("bp_dready0", 32'(dr_a), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_q", 32'(q_a), 32'h3C);
        chk("bp_hold_fill", 32'(fill_a), 32'h7);
        q_ready = 1'b1;
        #1;
        chk("bp_dready1", 32'(dr_a), 32'h1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        chk("bp_qff", 32'(q_a), 32'hFF);
        chk("bp_qv_stays", 32'(qv_a), 32'h1);
        chk("bp_fill0", 32'(fill_a), 32'h0);
        @(posedge clk); #1;

        // Flush after 3 bits, with a same-cycle bit that must be dropped
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("fl_fill3", 32'(fill_a), 32'h3);
        flush = 1'b1; d = 1'b1; d_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; d_valid = 1'b0;
        chk("fl_fill0", 32'(fill_a), 32'h0);
        chk("fl_qv", 32'(qv_a), 32'h0);
        send_word(8'h81, 8'h81, 8'h81, 1'b1);
        chk("fl_q81", 32'(q_a), 32'h81);

        // Bits 1,1,0,0,0,0,0,0: LSB-first 03, MSB-first C0
        send_word(8'h03, 8'h03, 8'hC0, 1'b1);
        chk("ord_lsb", 32'(q_a), 32'h03);
        chk("ord_msb", 32'(q_b), 32'hC0);
        @(posedge clk); #1;

        // Reset mid-word with a held word in the slot
        q_ready = 1'b0;
        send_word(8'h01, 8'h01, 8'h80, 1'b0);
        chk("mr_held_a", 32'(q_a), 32'h01);
        chk("mr_held_b", 32'(q_b), 32'h80);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        d_valid = 1'b0;
        chk("mr_fill5", 32'(fill_a), 32'h5);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_fill0", 32'(fill_a), 32'h0);
        chk("mr_qv0", 32'(qv_a), 32'h0);
        chk("mr_q0", 32'(q_a), 32'h0);
        rst = 1'b1; q_ready = 1'b1;
        send_word(8'h5A, 8'h5A, 8'h5A, 1'b1);
        chk("mr_q5a", 32'(q_a), 32'h5A);
        chk("mr_q5a_b", 32'(q_b), 32'h5A);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained_a", 32'(exp_a.size()), 32'h0);
        chk("sb_drained_b", 32'(exp_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
